// File: rtl/time_set_sequencer.sv
// time_set_sequencer: front-panel RUN / SET_HOURS / SET_MINUTES controller.
// Registers the Mode/Up levels, detects rising edges, issues one-cycle
// increment strobes, gates the seconds tick and blinks the edited digits.
// Optional build macro TIME_SET_AUTOREPEAT_EN adds Up-hold auto-repeat.
module time_set_sequencer #(
  parameter int unsigned TIMEOUT_CYC    = 32'd1000000000,
  parameter int unsigned BLINK_HALF_CYC = 32'd25000000
`ifdef TIME_SET_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY_CYC  = 32'd50000000,
  parameter int unsigned REPEAT_PERIOD_CYC = 32'd10000000
`endif
) (
  input  logic       Clk_100M,
  input  logic       nReset,
  input  logic       Mode,
  input  logic       Up,
  output logic       IncHour,
  output logic       IncMin,
  output logic       SecClear,
  output logic       TickEnable,
  output logic [3:0] DigitBlank,
  output logic [1:0] SetState
);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_HOURS   = 2'b01,
    S_MINUTES = 2'b10
  } state_t;

  state_t      state, state_next;
  logic        mode_q, mode_q2, up_q, up_q2;
  logic        mode_edge, up_edge, timeout, rep_strobe, inc_req;
  logic [31:0] idle_cnt, blink_cnt, blink_next;
  logic        phase, phase_next;
  logic        hour_next, min_next, secclr_next, tick_next;
  logic [3:0]  blank_next;

  // Input sampling and edge history
  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) begin
      mode_q  <= 1'b0;
      mode_q2 <= 1'b0;
      up_q    <= 1'b0;
      up_q2   <= 1'b0;
    end else begin
      mode_q  <= Mode;
      mode_q2 <= mode_q;
      up_q    <= Up;
      up_q2   <= up_q;
    end
  end

  assign mode_edge = mode_q & ~mode_q2;
  assign up_edge   = up_q & ~up_q2;

`ifdef TIME_SET_AUTOREPEAT_EN
  logic [31:0] hold_cnt;
  logic        hold_run, rep_active;

  // Repeat fires at the initial delay, then at each period while Up stays held
  always_comb begin
    rep_strobe = hold_run && up_q && !mode_edge && !up_edge && (state != S_RUN) &&
                 ((!rep_active && hold_cnt == REPEAT_DELAY_CYC) ||
                  ( rep_active && hold_cnt == REPEAT_PERIOD_CYC));
  end

  // Hold counter: counts cycles since the press or since the last repeat
  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) begin
      hold_cnt   <= '0;
      hold_run   <= 1'b0;
      rep_active <= 1'b0;
    end else if (state_next != state || mode_edge || !up_q) begin
      hold_cnt   <= '0;
      hold_run   <= 1'b0;
      rep_active <= 1'b0;
    end else if (up_edge && state != S_RUN) begin
      hold_cnt   <= 32'd1;
      hold_run   <= 1'b1;
      rep_active <= 1'b0;
    end else if (rep_strobe) begin
      hold_cnt   <= 32'd1;
      rep_active <= 1'b1;
    end else if (hold_run) begin
      hold_cnt   <= hold_cnt + 32'd1;
    end
  end
`else
  assign rep_strobe = 1'b0;
`endif

  // An Up edge or repeat strobe restarts the idle count, so it blocks timeout
  assign timeout = (state != S_RUN) && (idle_cnt == TIMEOUT_CYC - 32'd1) &&
                   !up_edge && !rep_strobe;
  assign inc_req = (up_edge && !mode_edge) || rep_strobe;

  // State register
  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) state <= S_RUN;
    else         state <= state_next;
  end

  // Next-state logic; Mode edge has priority over timeout
  always_comb begin
    state_next = state;
    unique case (state)
      S_RUN:     if (mode_edge) state_next = S_HOURS;
      S_HOURS:   if (mode_edge) state_next = S_MINUTES;
                 else if (timeout) state_next = S_RUN;
      S_MINUTES: if (mode_edge || timeout) state_next = S_RUN;
      default:   state_next = S_RUN;
    endcase
  end

  // Blink phase and output decode, computed from the next state
  always_comb begin
    blink_next = blink_cnt;
    phase_next = phase;
    if (state_next != state || state == S_RUN) begin
      blink_next = '0;
      phase_next = 1'b0;
    end else if (blink_cnt == BLINK_HALF_CYC - 32'd1) begin
      blink_next = '0;
      phase_next = ~phase;
    end else begin
      blink_next = blink_cnt + 32'd1;
    end
    hour_next   = inc_req && (state == S_HOURS);
    min_next    = inc_req && (state == S_MINUTES);
    secclr_next = (state != S_RUN) && (state_next == S_RUN);
    tick_next   = (state_next == S_RUN);
    unique case (state_next)
      S_HOURS:   blank_next = {phase_next, phase_next, 2'b00};
      S_MINUTES: blank_next = {2'b00, phase_next, phase_next};
      default:   blank_next = '0;
    endcase
  end

  // Idle and blink counters
  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) begin
      idle_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      blink_cnt <= blink_next;
      phase     <= phase_next;
      if (state_next != state || state_next == S_RUN || mode_edge || up_edge || rep_strobe)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 32'd1;
    end
  end

  // Registered outputs
  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) begin
      IncHour    <= 1'b0;
      IncMin     <= 1'b0;
      SecClear   <= 1'b0;
      TickEnable <= 1'b1;
      DigitBlank <= '0;
      SetState   <= 2'b00;
    end else begin
      IncHour    <= hour_next;
      IncMin     <= min_next;
      SecClear   <= secclr_next;
      TickEnable <= tick_next;
      DigitBlank <= blank_next;
      SetState   <= state_next;
    end
  end

endmodule
